// File: rtl/dcache_controller.sv
// Direct-mapped write-back write-allocate data cache between EX_MEM and a
// line-wide memory. Ports: p1_* CPU side (req/addr/data/stall), mem_* line bus.
module dcache_controller #(
    parameter int INDEX_W = 5,
    parameter int LINE_W  = 256,
    parameter int ADDR_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_data_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    localparam int NLINES = 1 << INDEX_W;
    localparam int TAG_W  = ADDR_W - 5 - INDEX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MISS,
        S_WRITE_BACK,
        S_ALLOCATE,
        S_REFILL
    } state_t;

    state_t state_q, state_d;

    logic [NLINES-1:0] valid_q, valid_d;
    logic [NLINES-1:0] dirty_q, dirty_d;

    // Latched {tag,index} of the missing access
    logic [ADDR_W-6:0] lat_line_q, lat_line_d;

    logic [TAG_W-1:0]  tag_q  [NLINES];
    logic [LINE_W-1:0] data_q [NLINES];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [2:0]         word;
    logic               req;
    logic               hit;
    logic [LINE_W-1:0]  cur_line;
    logic [INDEX_W-1:0] lat_idx;
    logic [TAG_W-1:0]   lat_tag;

    logic               line_we;
    logic               tag_we;
    logic [INDEX_W-1:0] line_wr_idx;
    logic [LINE_W-1:0]  line_wr_data;

    assign idx      = p1_addr_i[5+INDEX_W-1:5];
    assign tag      = p1_addr_i[ADDR_W-1:5+INDEX_W];
    assign word     = p1_addr_i[4:2];
    assign req      = p1_MemRead_i | p1_MemWrite_i;
    assign hit      = valid_q[idx] && (tag_q[idx] == tag);
    assign cur_line = data_q[idx];
    assign lat_idx  = lat_line_q[INDEX_W-1:0];
    assign lat_tag  = lat_line_q[ADDR_W-6:INDEX_W];

    assign p1_stall_o = (state_q != S_IDLE) | (req & ~hit);

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        lat_line_d   = lat_line_q;
        line_we      = 1'b0;
        tag_we       = 1'b0;
        line_wr_idx  = idx;
        line_wr_data = cur_line;
        p1_data_o    = '0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;

        case (state_q)
            S_IDLE: begin
                if (req && hit) begin
                    p1_data_o = cur_line[word*32 +: 32];
                    // MemWrite wins when both strobes are set
                    if (p1_MemWrite_i) begin
                        line_we = 1'b1;
                        line_wr_data[word*32 +: 32] = p1_data_i;
                        dirty_d[idx] = 1'b1;
                    end
                end else if (req) begin
                    lat_line_d = p1_addr_i[ADDR_W-1:5];
                    state_d    = S_MISS;
                end
            end
            S_MISS: begin
                if (valid_q[lat_idx] && dirty_q[lat_idx]) begin
                    state_d = S_WRITE_BACK;
                end else begin
                    state_d = S_ALLOCATE;
                end
            end
            S_WRITE_BACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag_q[lat_idx], lat_idx, 5'b0};
                mem_data_o   = data_q[lat_idx];
                if (mem_ack_i) begin
                    state_d = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {lat_line_q, 5'b0};
                if (mem_ack_i) begin
                    line_we          = 1'b1;
                    tag_we           = 1'b1;
                    line_wr_idx      = lat_idx;
                    line_wr_data     = mem_data_i;
                    valid_d[lat_idx] = 1'b1;
                    dirty_d[lat_idx] = 1'b0;
                    state_d          = S_REFILL;
                end
            end
            S_REFILL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            lat_line_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            lat_line_q <= lat_line_d;
        end
    end

    // Tag/data arrays carry no reset; valid bits qualify them
    always_ff @(posedge clk_i) begin
        if (!rst_i && line_we) begin
            data_q[line_wr_idx] <= line_wr_data;
        end
        if (!rst_i && tag_we) begin
            tag_q[line_wr_idx] <= lat_tag;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: directed scenarios then random traffic,
// checked against a per-index cache model and an associative memory model.
module tb_dcache_controller;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         p1_MemRead_i;
    logic         p1_MemWrite_i;
    logic [31:0]  p1_addr_i;
    logic [31:0]  p1_data_i;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    bit           mv [32];
    bit           md [32];
    logic [21:0]  mt [32];
    logic [255:0] ml [32];
    logic [255:0] mem [logic [31:0]];

    always #5 clk = ~clk;

    dcache_controller dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .p1_MemRead_i  (p1_MemRead_i),
        .p1_MemWrite_i (p1_MemWrite_i),
        .p1_addr_i     (p1_addr_i),
        .p1_data_i     (p1_data_i),
        .p1_data_o     (p1_data_o),
        .p1_stall_o    (p1_stall_o),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i)
    );

    task automatic chk(input string tg, input logic [255:0] got,
                       input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tg, got, exp);
        end
    endtask

    function automatic logic [255:0] get_line(input logic [31:0] a);
        logic [255:0] l;
        if (!mem.exists(a)) begin
            for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
            mem[a] = l;
        end
        return mem[a];
    endfunction

    // Called at a negedge; returns just after the posedge that takes the ack
    task automatic mem_phase(input bit wr, input logic [31:0] a,
                             input logic [255:0] line, input int lat);
        bit seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (mem_enable_o) seen = 1;
            else chk("stall_wait", p1_stall_o, 1);
        end
        if (!seen) begin
            chk("mem_timeout", 0, 1);
            return;
        end
        chk("mem_write", mem_write_o, wr);
        chk("mem_addr", mem_addr_o, a);
        if (wr) chk("wb_data", mem_data_o, line);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk("mem_hold", {mem_enable_o, mem_write_o, mem_addr_o},
                {1'b1, wr, a});
            chk("stall_hold", p1_stall_o, 1);
        end
        mem_ack_i = 1'b1;
        if (!wr) mem_data_i = line;
        @(posedge clk);
        #1;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
    endtask

    // Starts just after a posedge; ends just after the posedge completing it
    task automatic access(input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input int lat);
        logic [4:0]  idx = a[9:5];
        logic [21:0] tg  = a[31:10];
        int          w   = int'(a[4:2]);
        logic [31:0] va;
        logic [31:0] la;
        bit          hit;
        p1_MemRead_i  = !wr;
        p1_MemWrite_i = wr;
        p1_addr_i     = a;
        p1_data_i     = d;
        @(negedge clk);
        hit = mv[idx] && (mt[idx] == tg);
        chk("stall_req", p1_stall_o, !hit);
        if (!hit) begin
            if (mv[idx] && md[idx]) begin
                va = {mt[idx], idx, 5'b0};
                mem_phase(1, va, ml[idx], lat);
                mem[va] = ml[idx];
            end
            la = {tg, idx, 5'b0};
            mem_phase(0, la, get_line(la), lat);
            mv[idx] = 1;
            md[idx] = 0;
            mt[idx] = tg;
            ml[idx] = mem[la];
            @(negedge clk);
            chk("stall_refill", p1_stall_o, 1);
            chk("men_refill", mem_enable_o, 0);
            @(negedge clk);
            chk("stall_done", p1_stall_o, 0);
        end
        if (!wr) chk("rdata", p1_data_o, ml[idx][w*32 +: 32]);
        chk("men_idle", mem_enable_o, 0);
        @(posedge clk);
        if (wr) begin
            ml[idx][w*32 +: 32] = d;
            md[idx] = 1;
        end
        #1;
        p1_MemRead_i  = 0;
        p1_MemWrite_i = 0;
    endtask

    initial begin
        logic [255:0] l0;
        bit seen;
        rst_i = 1; p1_MemRead_i = 0; p1_MemWrite_i = 0;
        p1_addr_i = 0; p1_data_i = 0; mem_data_i = 0; mem_ack_i = 0;
        for (int i = 0; i < 32; i++) begin
            mv[i] = 0;
            md[i] = 0;
        end
        for (int i = 0; i < 8; i++) l0[i*32 +: 32] = 32'h100 + i;
        mem[32'h40] = l0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", {p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o,
                         p1_data_o}, '0);
        chk("rst_wbdata", mem_data_o, '0);
        @(posedge clk);
        #1 rst_i = 0;

        access(0, 32'h40, 0, 10);
        access(0, 32'h44, 0, 0);
        access(1, 32'h48, 32'hDEADBEEF, 0);
        access(0, 32'h48, 0, 0);
        chk("wb_src_word2", ml[2][95:64], 32'hDEADBEEF);
        access(0, 32'h440, 0, 3);
        chk("wb_mem_word2", mem[32'h40][95:64], 32'hDEADBEEF);
        chk("wb_mem_word0", mem[32'h40][31:0], 32'h100);
        access(1, 32'h880, 32'h55, 2);
        chk("wmiss_dirty", md[4], 1);
        access(0, 32'h080, 0, 1);
        chk("wb_880_word0", mem[32'h880][31:0], 32'h55);

        // Reset during ALLOCATE
        p1_MemRead_i = 1;
        p1_addr_i    = 32'h1000;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (mem_enable_o) seen = 1;
        end
        chk("alloc_seen", seen, 1);
        rst_i = 1;
        @(posedge clk);
        #1;
        rst_i = 0;
        p1_MemRead_i = 0;
        for (int i = 0; i < 32; i++) begin
            mv[i] = 0;
            md[i] = 0;
        end
        @(negedge clk);
        chk("rst_mid_men", mem_enable_o, 0);
        chk("rst_mid_stall", p1_stall_o, 0);
        mem_ack_i = 1;
        @(posedge clk);
        #1 mem_ack_i = 0;
        @(negedge clk);
        chk("late_ack_men", mem_enable_o, 0);
        chk("late_ack_stall", p1_stall_o, 0);
        @(posedge clk);
        #1;
        access(0, 32'h44, 0, 1);

        for (int k = 0; k < 300; k++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 5)
              | ($urandom_range(0, 7) << 2);
            access($urandom_range(0, 1) == 1, a, $urandom,
                   $urandom_range(0, 4));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
